cgra_sram_arbiter: RTL and testbench

- Shares one CGRA SRAM bank (single-port, 1-cycle read latency) between NumReq requesters, e.g. CGRA load/store columns and the system bus slave.
- Round-robin arbitration with an OBI-style req/gnt/rvalid handshake.
- Sequences the bank's retention input: enters retention after a programmable idle time and performs a timed wake-up before granting again.

---
 rtl/cgra_sram_arbiter.sv | 174 +++++++++++++++++
 tb/tb_cgra_sram_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cgra_sram_arbiter.sv
// Round-robin arbiter sharing one single-port CGRA SRAM bank, with idle-driven retention sequencing.
// Optional macro CGRA_SRAM_ARB_PRIO0_EN gives requester 0 fixed absolute priority over the others.
module cgra_sram_arbiter #(
   parameter int NumReq     = 2,
   parameter int AddrWidth  = 10,
   parameter int IdleCycles = 64,
   parameter int WakeCycles = 2
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [NumReq-1:0]           req_i,
   input  logic [NumReq-1:0]           we_i,
   input  logic [NumReq*AddrWidth-1:0] addr_i,
   input  logic [NumReq*32-1:0]        wdata_i,
   input  logic [NumReq*4-1:0]         be_i,
   output logic [NumReq-1:0]           gnt_o,
   output logic [NumReq-1:0]           rvalid_o,
   output logic [31:0]                 rdata_o,
   output logic                        sram_req_o,
   output logic                        sram_we_o,
   output logic [AddrWidth-1:0]        sram_addr_o,
   output logic [31:0]                 sram_wdata_o,
   output logic [3:0]                  sram_be_o,
   output logic                        sram_retentive_o,
   input  logic [31:0]                 sram_rdata_i
);

   localparam int PtrW  = $clog2(NumReq);
   localparam int CandW = PtrW + 1;
   localparam int IdleW = (IdleCycles > 0) ? $clog2(IdleCycles + 1) : 1;
   localparam int WakeW = (WakeCycles > 1) ? $clog2(WakeCycles) : 1;

   typedef enum logic [1:0] {ST_ACTIVE, ST_RET, ST_WAKE} state_t;

   state_t              state_reg, state_next;
   logic [PtrW-1:0]     ptr_reg, ptr_next;
   logic [IdleW-1:0]    idle_reg, idle_next;
   logic [WakeW-1:0]    wake_reg, wake_next;
   logic [NumReq-1:0]   rvalid_reg;
   logic                rd_pend_reg;
   logic [31:0]         rdata_hold_reg;
   logic                we_last_reg;
   logic [AddrWidth-1:0] addr_last_reg;
   logic [31:0]         wdata_last_reg;
   logic [3:0]          be_last_reg;

   logic [AddrWidth-1:0] addr_arr  [NumReq];
   logic [31:0]          wdata_arr [NumReq];
   logic [3:0]           be_arr    [NumReq];

   logic [NumReq-1:0]   elig;
   logic [NumReq-1:0]   gnt;
   logic [CandW-1:0]    cand;
   logic [PtrW-1:0]     pick_idx;
   logic                pick_any;
   logic                prio_hit;
   logic                fire;
   logic                any_req;

   genvar gi;
   generate
      for (gi = 0; gi < NumReq; gi++) begin : g_unpack
         assign addr_arr[gi]  = addr_i[gi*AddrWidth +: AddrWidth];
         assign wdata_arr[gi] = wdata_i[gi*32 +: 32];
         assign be_arr[gi]    = be_i[gi*4 +: 4];
      end
   endgenerate

   assign any_req = |req_i;

   // Search from the pointer upward with wrap; descending loop lets the nearest candidate win.
   always_comb begin
      elig     = req_i;
      prio_hit = 1'b0;
`ifdef CGRA_SRAM_ARB_PRIO0_EN
      elig[0]  = 1'b0;
      prio_hit = req_i[0];
`endif
      cand     = '0;
      pick_any = 1'b0;
      pick_idx = '0;
      for (int i = NumReq - 1; i >= 0; i--) begin
         cand = {1'b0, ptr_reg} + CandW'(i);
         if (cand >= CandW'(NumReq)) cand = cand - CandW'(NumReq);
         if (elig[cand[PtrW-1:0]]) begin
            pick_any = 1'b1;
            pick_idx = cand[PtrW-1:0];
         end
      end
      if (prio_hit) begin
         pick_any = 1'b1;
         pick_idx = '0;
      end
      fire = pick_any && (state_reg == ST_ACTIVE) && !rst_i;
      gnt  = '0;
      if (fire) gnt[pick_idx] = 1'b1;
      ptr_next = ptr_reg;
      if (fire && !prio_hit)
         ptr_next = (pick_idx == PtrW'(NumReq - 1)) ? '0 : pick_idx + PtrW'(1);
   end

   always_comb begin
      state_next = state_reg;
      idle_next  = idle_reg;
      wake_next  = wake_reg;
      case (state_reg)
         ST_ACTIVE: begin
            if (any_req)
               idle_next = '0;
            else if (idle_reg != IdleW'(IdleCycles))
               idle_next = idle_reg + IdleW'(1);
            if ((IdleCycles != 0) && !any_req && (idle_reg == IdleW'(IdleCycles)))
               state_next = ST_RET;
         end
         ST_RET: begin
            idle_next = '0;
            if (any_req) begin
               state_next = ST_WAKE;
               wake_next  = WakeW'(WakeCycles - 1);
            end
         end
         ST_WAKE: begin
            idle_next = '0;
            if (wake_reg == '0)
               state_next = ST_ACTIVE;
            else
               wake_next = wake_reg - WakeW'(1);
         end
         default: state_next = ST_ACTIVE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg      <= ST_ACTIVE;
         ptr_reg        <= '0;
         idle_reg       <= '0;
         wake_reg       <= '0;
         rvalid_reg     <= '0;
         rd_pend_reg    <= 1'b0;
         rdata_hold_reg <= '0;
         we_last_reg    <= 1'b0;
         addr_last_reg  <= '0;
         wdata_last_reg <= '0;
         be_last_reg    <= '0;
      end else begin
         state_reg   <= state_next;
         ptr_reg     <= ptr_next;
         idle_reg    <= idle_next;
         wake_reg    <= wake_next;
         rvalid_reg  <= gnt;
         rd_pend_reg <= fire && !we_i[pick_idx];
         if (rd_pend_reg) rdata_hold_reg <= sram_rdata_i;
         if (fire) begin
            we_last_reg    <= we_i[pick_idx];
            addr_last_reg  <= addr_arr[pick_idx];
            wdata_last_reg <= wdata_arr[pick_idx];
            be_last_reg    <= be_arr[pick_idx];
         end
      end
   end

   // Read data arrives from the bank in the rvalid cycle, so it is passed through and then held.
   assign rdata_o          = rd_pend_reg ? sram_rdata_i : rdata_hold_reg;
   assign gnt_o            = gnt;
   assign rvalid_o         = rvalid_reg;
   assign sram_req_o       = fire;
   assign sram_we_o        = fire ? we_i[pick_idx]      : we_last_reg;
   assign sram_addr_o      = fire ? addr_arr[pick_idx]  : addr_last_reg;
   assign sram_wdata_o     = fire ? wdata_arr[pick_idx] : wdata_last_reg;
   assign sram_be_o        = fire ? be_arr[pick_idx]    : be_last_reg;
   assign sram_retentive_o = (state_reg == ST_RET);

endmodule

// File: tb/tb_cgra_sram_arbiter.sv
// Scoreboard bench for cgra_sram_arbiter with two requesters and a behavioural 1-cycle SRAM bank.
module tb_cgra_sram_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req = 2'b00;
   logic [1:0]  we  = 2'b00;
   logic [9:0]  addr0 = '0, addr1 = '0;
   logic [31:0] wd0 = '0, wd1 = '0;
   logic [3:0]  be0 = 4'hF, be1 = 4'hF;

   logic [1:0]  gnt, rvalid;
   logic [31:0] rdata, sram_wdata;
   logic        sram_req, sram_we, sram_ret;
   logic [9:0]  sram_addr;
   logic [3:0]  sram_be;
   logic [31:0] sram_rdata = '0;

   logic [31:0] mem    [1024];
   logic [31:0] shadow [1024];

   typedef struct packed {
      logic [1:0]  rv;
      logic        rd;
      logic [31:0] data;
   } exp_t;
   exp_t sb[$];

   int n_total = 0;
   int n_bad   = 0;

`ifdef CGRA_SRAM_ARB_PRIO0_EN
   localparam bit Prio0 = 1'b1;
`else
   localparam bit Prio0 = 1'b0;
`endif

   always #5 clk = ~clk;

   cgra_sram_arbiter #(
      .NumReq(2), .AddrWidth(10), .IdleCycles(64), .WakeCycles(2)
   ) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we),
      .addr_i({addr1, addr0}), .wdata_i({wd1, wd0}), .be_i({be1, be0}),
      .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
      .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
      .sram_wdata_o(sram_wdata), .sram_be_o(sram_be),
      .sram_retentive_o(sram_ret), .sram_rdata_i(sram_rdata)
   );

   always @(posedge clk) begin
      if (sram_req) begin
         if (sram_we) begin
            for (int b = 0; b < 4; b++)
               if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
         end else begin
            sram_rdata <= mem[sram_addr];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock cycle: check combinational outputs and the response due now, queue the next response.
   task automatic tick(input logic [1:0] exp_g, input logic exp_ret);
      exp_t e, n;
      int   k;
      logic [9:0]  a;
      logic [31:0] d;
      logic [3:0]  be;
      @(negedge clk);
      check("gnt", {30'b0, gnt}, {30'b0, exp_g});
      check("sram_req", {31'b0, sram_req}, {31'b0, |exp_g});
      check("retentive", {31'b0, sram_ret}, {31'b0, exp_ret});
      if (sb.size() > 0) e = sb.pop_front();
      else e = '0;
      check("rvalid", {30'b0, rvalid}, {30'b0, e.rv});
      if (e.rd) check("rdata", rdata, e.data);
      n = '0;
      if (exp_g != 2'b00) begin
         k  = exp_g[1] ? 1 : 0;
         a  = k ? addr1 : addr0;
         d  = k ? wd1 : wd0;
         be = k ? be1 : be0;
         n.rv = exp_g;
         if (we[k]) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) shadow[a][b*8 +: 8] = d[b*8 +: 8];
         end else begin
            n.rd   = 1'b1;
            n.data = shadow[a];
         end
      end
      sb.push_back(n);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] g;
      for (int i = 0; i < 1024; i++) begin
         mem[i]    = '0;
         shadow[i] = '0;
      end
      // In reset with both requesting: everything must stay quiet.
      req = 2'b11;
      tick(2'b00, 1'b0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_addr", {22'b0, sram_addr}, 32'h0);
      req = 2'b00;
      tick(2'b00, 1'b0);
      sb.delete();
      rst = 1'b0;

      // Idle into retention: 65 edges with no request.
      for (int i = 0; i < 65; i++) tick(2'b00, 1'b0);
      tick(2'b00, 1'b1);

      // Wake-up by requester 1 write, granted in the 3rd cycle after the request.
      req = 2'b10; we = 2'b10; addr1 = 10'h005; wd1 = 32'hDEADBEEF; be1 = 4'hF;
      tick(2'b00, 1'b1);
      tick(2'b00, 1'b0);
      tick(2'b00, 1'b0);
      tick(2'b10, 1'b0);
      req = 2'b00; we = 2'b00;
      tick(2'b00, 1'b0);

      // Requester 0 reads it back, then a partial write and a read by requester 1.
      req = 2'b01; addr0 = 10'h005;
      tick(2'b01, 1'b0);
      req = 2'b00;
      tick(2'b00, 1'b0);
      req = 2'b01; we = 2'b01; wd0 = 32'h11223344; be0 = 4'b0011;
      tick(2'b01, 1'b0);
      req = 2'b10; we = 2'b00; addr1 = 10'h005;
      tick(2'b10, 1'b0);
      req = 2'b00; be0 = 4'hF;
      tick(2'b00, 1'b0);

      // Both requesting for 4 cycles: round-robin, full throughput.
      mem[7] = 32'hCAFE0007; shadow[7] = 32'hCAFE0007;
      req = 2'b11; we = 2'b00; addr0 = 10'h005; addr1 = 10'h007;
      for (int i = 0; i < 4; i++) begin
         g = (Prio0 || (i % 2 == 0)) ? 2'b01 : 2'b10;
         tick(g, 1'b0);
      end
      req = 2'b00;
      tick(2'b00, 1'b0);

      // Write immediately followed by a read of the same word.
      req = 2'b10; we = 2'b10; addr1 = 10'h009; wd1 = 32'hA5A55A5A;
      tick(2'b10, 1'b0);
      req = 2'b01; we = 2'b00; addr0 = 10'h009;
      tick(2'b01, 1'b0);
      req = 2'b00;
      tick(2'b00, 1'b0);

      // Reset the cycle after a read grant: its rvalid must be dropped.
      req = 2'b01; addr0 = 10'h007;
      tick(2'b01, 1'b0);
      rst = 1'b1; req = 2'b11;
      sb.delete();
      tick(2'b00, 1'b0);
      check("rst2_rdata", rdata, 32'h0);
      tick(2'b00, 1'b0);
      sb.delete();
      rst = 1'b0;
      tick(2'b01, 1'b0);
      req = 2'b00;
      tick(2'b00, 1'b0);
      tick(2'b00, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
